// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : Round-robin arbiter with a hold limit that drives an embedded 4:1 single-bit mux.
// Revision : 1.0
// ============================================================================
module rr_mux_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] w_in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel_nxt;
  logic       busy_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [1:0] last, last_nxt;

  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       win_vld;
  logic       release_ch;

  // Circular priority search: the loop runs downward so the nearest requester after base wins.
  always_comb begin
    base    = (state == GRANT) ? sel + 2'd1 : last + 2'd1;
    win     = base;
    win_vld = 1'b0;
    idx     = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign release_ch = !req[sel] || (hold_cnt == 8'(HOLD_MAX));

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << win;
          sel_nxt   = win;
          busy_nxt  = 1'b1;
          hold_nxt  = 8'd1;
          last_nxt  = win;
        end
      end
      GRANT: begin
        if (!release_ch) begin
          hold_nxt = hold_cnt + 8'd1;
        end else if (win_vld) begin
          // Hand over without a bubble; a sole requester wraps back onto itself.
          gnt_nxt  = 4'b0001 << win;
          sel_nxt  = win;
          hold_nxt = 8'd1;
          last_nxt = win;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          busy_nxt  = 1'b0;
          hold_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
        hold_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
      hold_cnt <= 8'd0;
      last     <= 2'd3;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
    end
  end

  assign y = busy & w_in[sel];

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed and random stimulus for rr_mux_arbiter against a behavioural owner model.
// Revision : 1.0
// ============================================================================
module tb_rr_mux_arbiter;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] w_in = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .w_in (w_in),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
  );

  always #5 clk = ~clk;

  // Model: owner index (-1 when idle), cycles held, previous winner, select.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = 3;
  int m_sel   = 0;
  bit m_valid = 1'b0;

  function automatic int pick(input int from, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(from + i) % 4]) return (from + i) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 3; m_sel = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      int w;
      if (m_owner < 0) begin
        w = pick(m_last, req);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_cnt = 1; m_last = w;
        end
      end else if (!req[m_owner] || m_cnt == HOLD) begin
        w = pick(m_owner, req);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_cnt = 1; m_last = w;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [3:0] eg;
      logic       eb, ey;
      eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      eb = (m_owner >= 0);
      ey = eb ? w_in[m_sel] : 1'b0;
      checks++;
      if (gnt !== eg || sel !== 2'(m_sel) || busy !== eb || y !== ey) begin
        errors++;
        $display("FAIL model t=%0t gnt=%b/%b sel=%0d/%0d busy=%b/%b y=%b/%b (actual/required)",
                 $time, gnt, eg, sel, m_sel, busy, eb, y, ey);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with everything requesting
    rst = 1'b1; req = 4'b1111; w_in = 4'b1111;
    tick(); tick();
    lit("rst_gnt", 32'(gnt), 32'h0);
    lit("rst_sel", 32'(sel), 32'h0);
    lit("rst_busy", 32'(busy), 32'h0);
    lit("rst_y", 32'(y), 32'h0);
    rst = 1'b0;
    tick();
    lit("first_gnt", 32'(gnt), 32'h1);

    // Full rotation, 4 cycles per owner
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      lit("rot_gnt", 32'(gnt), 32'(1 << (k / 4)));
      lit("rot_sel", 32'(sel), 32'(k / 4));
      lit("rot_busy", 32'(busy), 32'h1);
    end
    tick();
    lit("rot_wrap", 32'(gnt), 32'h1);

    // Early release: owner 0 drops during its second cycle
    req = 4'b1001;
    tick();
    lit("early_c2", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    lit("early_gnt", 32'(gnt), 32'h8);
    lit("early_sel", 32'(sel), 32'h3);

    // Fairness between 0 and 1
    req = 4'b0010;
    tick();
    lit("fair_own1", 32'(gnt), 32'h2);
    req = 4'b0011;
    tick(); tick(); tick(); tick();
    lit("fair_after1", 32'(gnt), 32'h1);
    tick(); tick(); tick(); tick();
    lit("fair_after0", 32'(gnt), 32'h2);

    // Sole requester holds continuously across hold-limit wraps
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      lit("sole_gnt", 32'(gnt), 32'h4);
      lit("sole_busy", 32'(busy), 32'h1);
    end
    req = 4'b0000;
    tick();
    lit("sole_end_gnt", 32'(gnt), 32'h0);
    lit("sole_end_busy", 32'(busy), 32'h0);
    lit("sole_end_sel", 32'(sel), 32'h2);

    // Data path
    req = 4'b0010;
    tick();
    lit("dp_sel", 32'(sel), 32'h1);
    w_in = 4'b0010; #1;
    lit("dp_y1", 32'(y), 32'h1);
    w_in = 4'b1101; #1;
    lit("dp_y0", 32'(y), 32'h0);
    req = 4'b0000;
    tick();
    w_in = 4'b1111; #1;
    lit("idle_y_ones", 32'(y), 32'h0);
    w_in = 4'b0000; #1;
    lit("idle_y_zeros", 32'(y), 32'h0);

    // Reset mid-grant
    req = 4'b0100; w_in = 4'b0100;
    tick();
    lit("mid_gnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    tick();
    lit("mid_rst_gnt", 32'(gnt), 32'h0);
    lit("mid_rst_sel", 32'(sel), 32'h0);
    lit("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0; req = 4'b1111;
    tick();
    lit("post_rst_gnt", 32'(gnt), 32'h1);

    // Random traffic with sticky requests and occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 3) req = 4'($urandom);
      w_in = 4'($urandom);
      tick();
      if ($urandom_range(0, 3) == 0) w_in = 4'($urandom);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
